// File: rtl/lfsr_bank_csr.sv
// Bank of NCH Fibonacci LFSR channels behind a UDM-bus CSR slave.
// Each channel steps from its loaded state COUNT times, then raises a sticky DONE bit that can drive irq_o.
module lfsr_bank_csr #(
    parameter int          NCH       = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] POLY      = 32'h80200003,
    parameter int          STEPS     = 1,
    parameter logic [31:0] BASE_ADDR = 32'h00001000
) (
    input  logic        clk_gen,
    input  logic        srst,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_RUN   = 1'b1;
    localparam logic [31:0]      WIN_LAST = 32'(16 * NCH + 7);
    localparam logic [WIDTH-1:0] TAPS     = POLY[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [31:0] off;
    logic        in_window, aligned, wr_en, rd_en, glb_wr;
    logic [3:0]  sel_idx;
    logic [1:0]  sel_reg;
    logic        unused_ok;

    assign off       = bus_addr_bi - BASE_ADDR;
    assign in_window = (bus_addr_bi >= BASE_ADDR) && (off <= WIN_LAST);
    assign aligned   = (off[1:0] == 2'b00);
    assign sel_idx   = off[7:4];
    assign sel_reg   = off[3:2];
    assign wr_en     = bus_req_i && bus_we_i && in_window && aligned;
    assign rd_en     = bus_req_i && !bus_we_i && in_window;
    assign glb_wr    = wr_en && (sel_idx == 4'(NCH));
    assign bus_ack_o = bus_req_i && in_window;
    assign unused_ok = ^bus_be_bi;

    logic [WIDTH-1:0] seed_w  [NCH];
    logic [WIDTH-1:0] state_w [NCH];
    logic [31:0]      count_w [NCH];
    logic [NCH-1:0]   busy_w, done_set, done_clr;
    logic [NCH-1:0]   done_q, done_d, irq_en_q, irq_en_d;
    logic             irq_q, resp_q;
    logic [31:0]      rdata_q, rdata_d;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [0:0]       fsm_q, fsm_d;
        logic [WIDTH-1:0] seed_q, seed_d, state_q, state_d, adv;
        logic [31:0]      count_q, count_d, rem_q, rem_d, k;
        logic             ch_wr, set_done, clr_done;

        assign ch_wr = wr_en && (sel_idx == 4'(gi));

        // Advance up to STEPS times, but never past the remaining count.
        always_comb begin
            k   = (rem_q < 32'(STEPS)) ? rem_q : 32'(STEPS);
            adv = state_q;
            for (int s = 0; s < STEPS; s++) begin
                if (32'(s) < k) adv = lfsr_step(adv);
            end
        end

        always_comb begin
            fsm_d    = fsm_q;
            seed_d   = seed_q;
            state_d  = state_q;
            count_d  = count_q;
            rem_d    = rem_q;
            set_done = 1'b0;
            clr_done = 1'b0;
            if (ch_wr && sel_reg == 2'd1) count_d = bus_wdata_bi;
            if (fsm_q == ST_IDLE) begin
                if (ch_wr && sel_reg == 2'd0) begin
                    seed_d  = bus_wdata_bi[WIDTH-1:0];
                    state_d = bus_wdata_bi[WIDTH-1:0];
                end else if (ch_wr && sel_reg == 2'd2 && bus_wdata_bi[1:0] == 2'b01) begin
                    if (count_q == 32'd0) begin
                        set_done = 1'b1;
                    end else begin
                        fsm_d    = ST_RUN;
                        rem_d    = count_q;
                        clr_done = 1'b1;
                    end
                end
            end else begin
                if (ch_wr && sel_reg == 2'd2 && bus_wdata_bi[1]) begin
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = adv;
                    rem_d   = rem_q - k;
                    if (rem_d == 32'd0) begin
                        fsm_d    = ST_IDLE;
                        set_done = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk_gen) begin
            if (srst) begin
                fsm_q   <= ST_IDLE;
                seed_q  <= WIDTH'(1);
                state_q <= WIDTH'(1);
                count_q <= '0;
                rem_q   <= '0;
            end else begin
                fsm_q   <= fsm_d;
                seed_q  <= seed_d;
                state_q <= state_d;
                count_q <= count_d;
                rem_q   <= rem_d;
            end
        end

        assign seed_w[gi]   = seed_q;
        assign state_w[gi]  = state_q;
        assign count_w[gi]  = count_q;
        assign busy_w[gi]   = (fsm_q == ST_RUN);
        assign done_set[gi] = set_done;
        assign done_clr[gi] = clr_done;
    end

    // Hardware set is applied last so it beats a coincident W1C.
    always_comb begin
        done_d   = done_q;
        irq_en_d = irq_en_q;
        if (glb_wr && sel_reg == 2'd0) done_d = done_d & ~bus_wdata_bi[NCH-1:0];
        if (glb_wr && sel_reg == 2'd1) irq_en_d = bus_wdata_bi[NCH-1:0];
        done_d = (done_d & ~done_clr) | done_set;
    end

    always_comb begin
        rdata_d = '0;
        if (aligned) begin
            for (int c = 0; c < NCH; c++) begin
                if (sel_idx == 4'(c)) begin
                    case (sel_reg)
                        2'd0:    rdata_d = 32'(seed_w[c]);
                        2'd1:    rdata_d = count_w[c];
                        2'd2:    rdata_d = {29'd0, state_w[c] == '0, done_q[c], busy_w[c]};
                        default: rdata_d = 32'(state_w[c]);
                    endcase
                end
            end
            if (sel_idx == 4'(NCH)) begin
                if (sel_reg == 2'd0) rdata_d = 32'(done_q);
                if (sel_reg == 2'd1) rdata_d = 32'(irq_en_q);
            end
        end
    end

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            done_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(done_d & irq_en_d);
            resp_q   <= rd_en;
            if (rd_en) rdata_q <= rdata_d;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign irq_o        = irq_q;
endmodule

// File: tb/tb_lfsr_bank_csr.sv
// Directed bench for lfsr_bank_csr: WIDTH=8, POLY=0xB8; instance a has STEPS=1, instance b STEPS=3.
// Both instances see the same bus stimulus; reads return each instance's data.
module tb_lfsr_bank_csr;
    localparam logic [31:0] BASE = 32'h00001000;

    logic        clk_gen = 1'b0;
    logic        srst = 1'b1;
    logic        bus_req_i = 1'b0, bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = '0, bus_wdata_bi = '0;
    logic [3:0]  bus_be_bi = 4'hF;
    logic        ack_a, resp_a, irq_a, ack_b, resp_b, irq_b;
    logic [31:0] rdata_a, rdata_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_gen = ~clk_gen;

    lfsr_bank_csr #(.NCH(4), .WIDTH(8), .POLY(32'h000000B8), .STEPS(1), .BASE_ADDR(BASE)) dut_a (
        .clk_gen(clk_gen), .srst(srst), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
        .bus_addr_bi(bus_addr_bi), .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
        .bus_ack_o(ack_a), .bus_resp_o(resp_a), .bus_rdata_bo(rdata_a), .irq_o(irq_a));

    lfsr_bank_csr #(.NCH(4), .WIDTH(8), .POLY(32'h000000B8), .STEPS(3), .BASE_ADDR(BASE)) dut_b (
        .clk_gen(clk_gen), .srst(srst), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
        .bus_addr_bi(bus_addr_bi), .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
        .bus_ack_o(ack_b), .bus_resp_o(resp_b), .bus_rdata_bo(rdata_b), .irq_o(irq_b));

    function automatic logic [31:0] ra(input int ch, input int r);
        return BASE + 32'(16 * ch + 4 * r);
    endfunction

    // Called on a falling edge; the write is accepted on the following rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = a; bus_wdata_bi = d;
        @(negedge clk_gen);
        bus_req_i = 1'b0; bus_we_i = 1'b0;
        $display("  wr  addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] da, output logic [31:0] db,
                            output logic ack, output logic resp);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = a;
        #1 ack = ack_a;
        @(negedge clk_gen);
        bus_req_i = 1'b0;
        resp = resp_a; da = rdata_a; db = rdata_b;
        $display("  rd  addr=%h ack=%0d resp=%0d a=%h b=%h", a, ack, resp, da, db);
    endtask

    task automatic test_reset();
        logic [31:0] addrs [7];
        logic [31:0] exps [7];
        logic [31:0] da, db;
        logic ack, resp;
        addrs = '{ra(0,0), ra(0,1), ra(0,2), ra(0,3), ra(3,3), ra(4,0), ra(4,1)};
        exps  = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0};
        srst = 1'b1;
        repeat (3) @(negedge clk_gen);
        srst = 1'b0;
        checks++;
        if ({irq_a, resp_a, rdata_a} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs irq=%0d resp=%0d rdata=%h want 0 0 0", irq_a, resp_a, rdata_a);
        end
        for (int i = 0; i < 7; i++) begin
            bus_read(addrs[i], da, db, ack, resp);
            checks++;
            if (da !== exps[i] || ack !== 1'b1 || resp !== 1'b1) begin
                failures++;
                $display("FAIL reset_reg[%0d] got %h ack=%0d resp=%0d want %h", i, da, ack, resp, exps[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] da, db;
        logic ack, resp;
        int cyc;
        bus_write(ra(0,0), 32'h01);
        bus_write(ra(0,1), 32'd4);
        bus_write(ra(4,1), 32'h1);
        bus_write(ra(0,2), 32'h1);
        bus_read(ra(0,2), da, db, ack, resp);
        checks++;
        if (da !== 32'h1) begin
            failures++;
            $display("FAIL basic_busy status=%h want 00000001", da);
        end
        cyc = 1;
        while (!irq_a && cyc < 20) begin
            @(negedge clk_gen);
            cyc++;
        end
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL basic_done_latency cycles=%0d want 4", cyc);
        end
        bus_read(ra(0,3), da, db, ack, resp);
        checks++;
        if (da !== 32'h11) begin
            failures++;
            $display("FAIL basic_state got %h want 00000011", da);
        end
        bus_read(ra(0,2), da, db, ack, resp);
        checks++;
        if (da !== 32'h2) begin
            failures++;
            $display("FAIL basic_status_done got %h want 00000002", da);
        end
        bus_read(ra(4,0), da, db, ack, resp);
        checks++;
        if (da !== 32'h1) begin
            failures++;
            $display("FAIL basic_done_reg got %h want 00000001", da);
        end
    endtask

    task automatic test_period();
        logic [31:0] da, db;
        logic ack, resp;
        int ca, cb;
        ca = -1; cb = -1;
        bus_write(ra(4,0), 32'hF);
        bus_write(ra(0,0), 32'h01);
        bus_write(ra(0,1), 32'd255);
        bus_write(ra(0,2), 32'h1);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk_gen);
            if (irq_a && ca < 0) ca = i;
            if (irq_b && cb < 0) cb = i;
            if (ca >= 0 && cb >= 0) break;
        end
        checks++;
        if (ca !== 255) begin
            failures++;
            $display("FAIL period_cycles_steps1 cycles=%0d want 255", ca);
        end
        checks++;
        if (cb !== 85) begin
            failures++;
            $display("FAIL period_cycles_steps3 cycles=%0d want 85", cb);
        end
        bus_read(ra(0,3), da, db, ack, resp);
        checks++;
        if (da !== 32'h01 || db !== 32'h01) begin
            failures++;
            $display("FAIL period_state a=%h b=%h want 00000001", da, db);
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] da, db;
        logic ack, resp;
        bus_write(ra(4,0), 32'hF);
        bus_write(ra(4,1), 32'h4);
        bus_write(ra(2,0), 32'h5A);
        bus_write(ra(2,2), 32'h1);
        checks++;
        if (irq_a !== 1'b1) begin
            failures++;
            $display("FAIL zero_count_done irq=%0d want 1", irq_a);
        end
        bus_read(ra(2,3), da, db, ack, resp);
        checks++;
        if (da !== 32'h5A) begin
            failures++;
            $display("FAIL zero_count_state got %h want 0000005a", da);
        end
        bus_write(ra(3,0), 32'h0);
        bus_write(ra(3,1), 32'd3);
        bus_write(ra(3,2), 32'h1);
        repeat (5) @(negedge clk_gen);
        bus_read(ra(3,2), da, db, ack, resp);
        checks++;
        if (da !== 32'h6) begin
            failures++;
            $display("FAIL zero_lock_status got %h want 00000006", da);
        end
        bus_read(ra(3,3), da, db, ack, resp);
        checks++;
        if (da !== 32'h0) begin
            failures++;
            $display("FAIL zero_lock_state got %h want 00000000", da);
        end
    endtask

    task automatic test_abort();
        logic [31:0] addrs [5];
        logic [31:0] exps [5];
        logic [31:0] da, db;
        logic ack, resp;
        addrs = '{ra(0,2), ra(0,3), ra(0,0), ra(0,1), ra(4,0)};
        exps  = '{32'h0, 32'h38, 32'h01, 32'd7, 32'h0};
        bus_write(ra(4,0), 32'hF);
        bus_write(ra(4,1), 32'h1);
        bus_write(ra(0,1), 32'd1000);
        bus_write(ra(0,2), 32'h1);
        bus_write(ra(0,0), 32'h77);
        bus_write(ra(0,2), 32'h1);
        bus_write(ra(0,1), 32'd7);
        repeat (6) @(negedge clk_gen);
        // Nine steps from 0x01 have elapsed when the abort lands: 02 04 08 11 23 47 8E 1C 38.
        bus_write(ra(0,2), 32'h3);
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], da, db, ack, resp);
            checks++;
            if (da !== exps[i]) begin
                failures++;
                $display("FAIL abort_reg[%0d] got %h want %h", i, da, exps[i]);
            end
        end
        repeat (3) @(negedge clk_gen);
        checks++;
        if (irq_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_irq irq=%0d want 0", irq_a);
        end
    endtask

    task automatic test_irq();
        logic [31:0] da, db;
        logic ack, resp;
        bus_write(ra(4,0), 32'hF);
        bus_write(ra(4,1), 32'h2);
        bus_write(ra(1,1), 32'd2);
        bus_write(ra(1,2), 32'h1);
        repeat (2) @(negedge clk_gen);
        checks++;
        if (irq_a !== 1'b1) begin
            failures++;
            $display("FAIL irq_raise irq=%0d want 1", irq_a);
        end
        bus_write(ra(4,0), 32'h2);
        checks++;
        if (irq_a !== 1'b0) begin
            failures++;
            $display("FAIL irq_w1c_clear irq=%0d want 0", irq_a);
        end
        bus_read(ra(4,0), da, db, ack, resp);
        checks++;
        if (da !== 32'h0) begin
            failures++;
            $display("FAIL irq_done_cleared got %h want 00000000", da);
        end
        bus_write(ra(1,1), 32'd3);
        bus_write(ra(1,2), 32'h1);
        repeat (2) @(negedge clk_gen);
        bus_write(ra(4,0), 32'h2);
        bus_read(ra(4,0), da, db, ack, resp);
        checks++;
        if (da !== 32'h2 || irq_a !== 1'b1) begin
            failures++;
            $display("FAIL irq_w1c_vs_set done=%h irq=%0d want 00000002 1", da, irq_a);
        end
    endtask

    task automatic test_window();
        logic [31:0] da, db;
        logic ack, resp;
        bus_read(ra(4,0) + 32'd2, da, db, ack, resp);
        checks++;
        if (ack !== 1'b1 || resp !== 1'b1 || da !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read ack=%0d resp=%0d data=%h want 1 1 0", ack, resp, da);
        end
        bus_read(ra(4,1), da, db, ack, resp);
        checks++;
        if (da !== 32'h2 || resp !== 1'b1) begin
            failures++;
            $display("FAIL irq_en_read got %h resp=%0d want 00000002 1", da, resp);
        end
        bus_read(BASE + 32'h48, da, db, ack, resp);
        checks++;
        if (ack !== 1'b0 || resp !== 1'b0) begin
            failures++;
            $display("FAIL above_window ack=%0d resp=%0d want 0 0", ack, resp);
        end
        bus_read(BASE - 32'd4, da, db, ack, resp);
        checks++;
        if (ack !== 1'b0 || resp !== 1'b0) begin
            failures++;
            $display("FAIL below_window ack=%0d resp=%0d want 0 0", ack, resp);
        end
    endtask

    task automatic test_srst_midrun();
        logic [31:0] addrs [6];
        logic [31:0] exps [6];
        logic [31:0] da, db;
        logic ack, resp;
        addrs = '{ra(0,2), ra(0,3), ra(0,0), ra(0,1), ra(4,0), ra(4,1)};
        exps  = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
        bus_write(ra(4,0), 32'hF);
        bus_write(ra(4,1), 32'h1);
        bus_write(ra(0,1), 32'd50);
        bus_write(ra(0,2), 32'h1);
        repeat (5) @(negedge clk_gen);
        srst = 1'b1;
        @(negedge clk_gen);
        srst = 1'b0;
        checks++;
        if (irq_a !== 1'b0 || resp_a !== 1'b0) begin
            failures++;
            $display("FAIL srst_outputs irq=%0d resp=%0d want 0 0", irq_a, resp_a);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], da, db, ack, resp);
            checks++;
            if (da !== exps[i]) begin
                failures++;
                $display("FAIL srst_reg[%0d] got %h want %h", i, da, exps[i]);
            end
        end
        repeat (60) @(negedge clk_gen);
        bus_read(ra(4,0), da, db, ack, resp);
        checks++;
        if (da !== 32'h0) begin
            failures++;
            $display("FAIL srst_no_done got %h want 00000000", da);
        end
    endtask

    initial begin
        @(negedge clk_gen);
        test_reset();
        test_basic();
        test_period();
        test_count_zero();
        test_abort();
        test_irq();
        test_window();
        test_srst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
